cache_ctrl: RTL
===============

// Module: cache_ctrl
// PURPOSE
//   Direct-mapped, write-through, no-write-allocate L1 data cache between the
//   single-cycle RISC-V core and main memory. Read hits return data the same
//   cycle. Misses and all stores stall the core while this block initiates the
//   4-beat main-memory transfer (read_en/write_en held until ready), and owns
//   the request side of that handshake.
// PARAMETERS
//   WIDTH   32    data word width
//   DEPTH   1024  main-memory depth in words; ADDR_W = $clog2(DEPTH)
//   LINES   16    cache lines, power of 2; IDX_W = $clog2(LINES)
//   (derived) block = 4 words; TAG_W = ADDR_W - 2 - IDX_W
// PORTS
//   clk          in   1        clock, rising edge
//   reset        in   1        asynchronous, active-low reset
//   cpu_addr     in   ADDR_W   word address {tag, index, offset[1:0]}
//   cpu_read     in   1        load request, level, held while cpu_stall=1
//   cpu_write    in   1        store request, level, held while cpu_stall=1
//   cpu_wdata    in   WIDTH    store data
//   cpu_rdata    out  WIDTH    load data, valid when cpu_read & ~cpu_stall
//   cpu_stall    out  1        freeze core this cycle (combinational)
//   mem_address  out  ADDR_W   memory word address
//   mem_read_en  out  1        block-read request
//   mem_write_en out  1        word-write request
//   mem_wdata    out  WIDTH    write data to memory
//   mem_ready    in   1        memory transfer complete
//   mem_rdata    in   4*WIDTH  fetched block; word i at [WIDTH*i +: WIDTH]
// BEHAVIOUR
//   Storage: per line valid bit, TAG_W tag, 4 data words. hit = valid[idx] &
//     tag[idx]==cpu_addr tag field. cpu_rdata = word[offset] of line idx (mux).
//   FSM states IDLE, FILL, WRITE. Reset: state IDLE, all valid=0, data/tags
//     don't-care; combinationally then mem_*_en=0, cpu_stall=0 (no request).
//   IDLE: cpu_write -> WRITE (write wins if cpu_read also high; illegal combo).
//     cpu_read & hit -> stay, stall=0. cpu_read & miss -> FILL. else stay.
//   cpu_stall = (IDLE & (cpu_write | cpu_read & ~hit)) | (state != IDLE).
//   FILL: mem_read_en = ~mem_ready; mem_address = {cpu_addr[ADDR_W-1:2],2'b00}.
//     On edge with mem_ready=1: load mem_rdata into line, set tag, valid=1,
//     -> IDLE. Next cycle is a hit; core completes load.
//   WRITE: mem_write_en = ~mem_ready; mem_address = cpu_addr; mem_wdata =
//     cpu_wdata. On edge with mem_ready=1: if hit, update cached word[offset]
//     (tag/valid untouched); miss leaves cache unchanged; -> IDLE.
//   Enable drop rule: enables deassert combinationally in the cycle mem_ready
//     is high, so memory never sees an enable on the edge after its count
//     wraps; memory's counter stays aligned and its ready clears next edge.
//   Back-to-back: new request in the IDLE cycle after completion is legal;
//     mem_ready is still low by then (memory clears it on the idle edge).
//   Latency with companion memory: read miss and store each stall 6 cycles
//     (1 IDLE decision + 4 beats + ready cycle); read hit 0.
//   Enables are never both high. mem_rdata sampled only on FILL completion.
//   Reset mid-transfer: FSM -> IDLE, all lines invalid, enables drop at once;
//     partial fill never becomes valid.
// TESTING
//   Reset, read addr 0x004 -> stall 6 cycles, mem_read_en 4 cycles at addr
//     0x004, then cpu_rdata = mem word 0x004, valid[1]=1.
//   Read 0x005..0x007 after that fill -> stall=0, no mem_read_en, data match.
//   Write 0x006 data 0xDEADBEEF (hit) -> mem_write_en 4 cycles, stall 6;
//     then read 0x006 -> 0xDEADBEEF with no memory access.
//   Write 0x3F0 (miss) -> memory updated, line 12 stays invalid; read 0x3F0
//     -> miss fill returns 0xDEADBEEF... i.e. the written value.
//   Conflict: read 0x010 then 0x110 (same index 4) -> second misses, refills;
//     re-read 0x010 misses again.
//   Assert reset in 3rd FILL beat -> enables low immediately; after release
//     read same addr misses, full 6-cycle fill, correct data.

Source files
------------

// File: rtl/cache_ctrl_if.sv
// CPU-side and memory-side signal bundle for the L1 data cache controller.
interface cache_ctrl_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 10
);
    // core side
    logic [ADDR_W-1:0]  cpu_addr;
    logic               cpu_read;
    logic               cpu_write;
    logic [WIDTH-1:0]   cpu_wdata;
    logic [WIDTH-1:0]   cpu_rdata;
    logic               cpu_stall;
    // main-memory side
    logic [ADDR_W-1:0]  mem_address;
    logic               mem_read_en;
    logic               mem_write_en;
    logic [WIDTH-1:0]   mem_wdata;
    logic               mem_ready;
    logic [4*WIDTH-1:0] mem_rdata;

    // cache controller view
    modport slave (
        input  cpu_addr, cpu_read, cpu_write, cpu_wdata,
        output cpu_rdata, cpu_stall,
        output mem_address, mem_read_en, mem_write_en, mem_wdata,
        input  mem_ready, mem_rdata
    );

    // environment view: core plus main memory
    modport master (
        output cpu_addr, cpu_read, cpu_write, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        input  mem_address, mem_read_en, mem_write_en, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache controller.
// Read hits complete with zero stall; misses fill a 4-word block, stores are
// always written to memory and update the cached word only on a hit.
module cache_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned LINES = 16
) (
    input  logic         clk,
    input  logic         reset,
    cache_ctrl_if.slave  bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned TAG_W  = ADDR_W - 2 - IDX_W;
    localparam int unsigned BLK_W  = 4 * WIDTH;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags   [LINES];
    logic [BLK_W-1:0] blocks [LINES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       off;
    logic             hit;
    logic             fill_done;
    logic             write_done;

    // Address decode and tag compare
    always_comb begin
        idx = bus.cpu_addr[2 +: IDX_W];
        tag = bus.cpu_addr[ADDR_W-1 -: TAG_W];
        off = bus.cpu_addr[1:0];
        hit = valid[idx] && (tags[idx] == tag);
    end

    // Load data mux; only meaningful on a hit
    always_comb begin
        bus.cpu_rdata = blocks[idx][WIDTH*off +: WIDTH];
    end

    // Next-state and combinational handshake outputs
    always_comb begin
        state_nxt        = state;
        bus.cpu_stall    = 1'b0;
        bus.mem_read_en  = 1'b0;
        bus.mem_write_en = 1'b0;
        bus.mem_address  = bus.cpu_addr;
        bus.mem_wdata    = bus.cpu_wdata;
        fill_done        = 1'b0;
        write_done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cpu_write) begin
                    state_nxt     = WRITE;
                    bus.cpu_stall = 1'b1;
                end else if (bus.cpu_read && !hit) begin
                    state_nxt     = FILL;
                    bus.cpu_stall = 1'b1;
                end
            end
            FILL: begin
                bus.cpu_stall   = 1'b1;
                bus.mem_address = {bus.cpu_addr[ADDR_W-1:2], 2'b00};
                // drop the request in the ready cycle so memory's beat counter stays aligned
                bus.mem_read_en = !bus.mem_ready;
                if (bus.mem_ready) begin
                    fill_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                bus.cpu_stall    = 1'b1;
                bus.mem_write_en = !bus.mem_ready;
                if (bus.mem_ready) begin
                    write_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Valid bits; a fill interrupted by reset never sets its line valid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else if (fill_done) begin
            valid[idx] <= 1'b1;
        end
    end

    // Tag and data arrays: block load on fill, single-word update on store hit
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tags[idx]   <= tag;
            blocks[idx] <= bus.mem_rdata;
        end else if (write_done && hit) begin
            blocks[idx][WIDTH*off +: WIDTH] <= bus.cpu_wdata;
        end
    end
endmodule
